// File: rtl/abp_pkg.sv
// Constants and state encoding shared by the ABP packet receiver and transmitter.
package abp_pkg;

  localparam int ABP_PACKET_SIZE = 64;
  localparam int ABP_VALUE_SIZE  = 4;
  localparam int ABP_BIT_OFFSET  = ABP_PACKET_SIZE - 1;

  typedef enum logic [1:0] {
    RECV,
    HOLD,
    DROP
  } abp_rx_state_t;

endpackage

// File: rtl/abp_packet_rx_if.sv
// MAC RX byte stream plus the ABP hyperdata handshake, as seen by the receiver (slave) and its environment (master).
interface abp_packet_rx_if
  import abp_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int VALUE_SIZE = ABP_VALUE_SIZE
);

  logic                    s_eth_rx_tvalid;
  logic [DATA_WIDTH-1:0]   s_eth_rx_tdata;
  logic                    s_eth_rx_tlast;
  logic                    s_eth_rx_tuser;
  logic                    s_eth_rx_tready;
  logic                    m_abp_valid;
  logic                    m_abp_ready;
  logic [VALUE_SIZE*8-1:0] m_abp_value;
  logic                    m_abp_bit;

  modport master (
    output s_eth_rx_tvalid, s_eth_rx_tdata, s_eth_rx_tlast, s_eth_rx_tuser, m_abp_ready,
    input  s_eth_rx_tready, m_abp_valid, m_abp_value, m_abp_bit
  );

  modport slave (
    input  s_eth_rx_tvalid, s_eth_rx_tdata, s_eth_rx_tlast, s_eth_rx_tuser, m_abp_ready,
    output s_eth_rx_tready, m_abp_valid, m_abp_value, m_abp_bit
  );

endinterface

// File: rtl/abp_packet_rx.sv
// Alternating-bit-protocol receiver: parses fixed-size frames from the MAC RX stream into one
// value/bit hyperdata transfer per good frame, dropping and flagging malformed frames.
module abp_packet_rx
  import abp_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int VALUE_SIZE  = ABP_VALUE_SIZE,
  parameter int PACKET_SIZE = ABP_PACKET_SIZE
) (
  input  logic             aclk,
  input  logic             resetn,
  abp_packet_rx_if.slave   rx,
  output logic             frame_error,
  output logic             busy
);

  localparam int CW = $clog2(PACKET_SIZE) + 1;
  localparam int IW = (VALUE_SIZE > 1) ? $clog2(VALUE_SIZE) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(PACKET_SIZE - 1);
  localparam logic [CW-1:0] VAL_END  = CW'(VALUE_SIZE);

  abp_rx_state_t            state;
  logic [CW-1:0]            cnt;
  logic                     tready;
  logic                     valid;
  logic [VALUE_SIZE*8-1:0]  value;
  logic                     abp_bit;
  logic [VALUE_SIZE-1:0][7:0] shadow;
  logic [IW-1:0]            slot;
  logic                     beat;

  assign rx.s_eth_rx_tready = tready;
  assign rx.m_abp_valid     = valid;
  assign rx.m_abp_value     = value;
  assign rx.m_abp_bit       = abp_bit;

  assign beat = rx.s_eth_rx_tvalid && tready;
  // Byte 0 lands in the most significant slot.
  assign slot = IW'(VAL_END - CW'(1) - cnt);

  always_ff @(posedge aclk) begin
    if (state == RECV && beat && cnt < VAL_END) begin
      shadow[slot] <= rx.s_eth_rx_tdata[7:0];
    end
  end

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      state       <= RECV;
      cnt         <= '0;
      tready      <= 1'b0;
      valid       <= 1'b0;
      value       <= '0;
      abp_bit     <= 1'b0;
      frame_error <= 1'b0;
      busy        <= 1'b0;
    end else begin
      frame_error <= 1'b0;
      case (state)
        RECV: begin
          tready <= 1'b1;
          if (beat) begin
            if (rx.s_eth_rx_tlast) begin
              cnt <= '0;
              if (cnt == LAST_IDX && !rx.s_eth_rx_tuser) begin
                value   <= shadow;
                abp_bit <= rx.s_eth_rx_tdata[0];
                valid   <= 1'b1;
                tready  <= 1'b0;
                busy    <= 1'b1;
                state   <= HOLD;
              end else begin
                frame_error <= 1'b1;
                busy        <= 1'b0;
              end
            end else if (cnt == LAST_IDX) begin
              // Frame runs past its fixed length: flag once, swallow the rest.
              frame_error <= 1'b1;
              busy        <= 1'b1;
              state       <= DROP;
            end else begin
              cnt  <= cnt + CW'(1);
              busy <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (valid && rx.m_abp_ready) begin
            valid  <= 1'b0;
            tready <= 1'b1;
            busy   <= 1'b0;
            state  <= RECV;
          end
        end
        DROP: begin
          tready <= 1'b1;
          if (beat && rx.s_eth_rx_tlast) begin
            cnt   <= '0;
            busy  <= 1'b0;
            state <= RECV;
          end
        end
        default: begin
          state  <= RECV;
          cnt    <= '0;
          tready <= 1'b0;
          valid  <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_abp_packet_rx.sv
// Self-checking bench for abp_packet_rx: table of frames with a value scoreboard, plus hold and reset sequences.
module tb_abp_packet_rx;
  import abp_pkg::*;

  logic aclk = 1'b0;
  logic resetn = 1'b0;
  logic frame_error;
  logic busy;

  abp_packet_rx_if #(.DATA_WIDTH(8), .VALUE_SIZE(4)) bus ();

  abp_packet_rx #(.DATA_WIDTH(8), .VALUE_SIZE(4), .PACKET_SIZE(64)) dut (
    .aclk        (aclk),
    .resetn      (resetn),
    .rx          (bus),
    .frame_error (frame_error),
    .busy        (busy)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    int          len;
    logic [31:0] val;
    logic [7:0]  bb;
    logic        user_last;
    logic        gaps;
    logic        ok;
    logic        err;
  } frame_rec_t;

  int n_tests = 0;
  int n_fail = 0;
  int errs_seen = 0;
  int exp_errs = 0;
  logic [32:0] sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard side: every completed hyperdata handshake must match the oldest good frame sent.
  always @(negedge aclk) begin
    if (resetn) begin
      if (frame_error) errs_seen++;
      if (bus.m_abp_valid && bus.m_abp_ready) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_unexpected: got value %0h with no frame pending", bus.m_abp_value);
        end else begin
          logic [32:0] e;
          e = sb.pop_front();
          check("sb_value", 64'(bus.m_abp_value), 64'(e[32:1]));
          check("sb_bit", 64'(bus.m_abp_bit), 64'(e[0]));
        end
      end
    end
  end

  task automatic send_beat(input logic [7:0] d, input logic last, input logic user, input int gap);
    int t;
    for (int g = 0; g < gap; g++) begin
      @(negedge aclk);
      bus.s_eth_rx_tvalid = 1'b0;
    end
    @(negedge aclk);
    bus.s_eth_rx_tvalid = 1'b1;
    bus.s_eth_rx_tdata  = d;
    bus.s_eth_rx_tlast  = last;
    bus.s_eth_rx_tuser  = user;
    t = 0;
    while (!bus.s_eth_rx_tready) begin
      @(negedge aclk);
      t++;
      if (t > 200) begin
        n_tests++;
        n_fail++;
        $display("FAIL tready_timeout: got tready 0 for %0d cycles, required 1", t);
        break;
      end
    end
  endtask

  // Returns at the first negedge after the tlast beat was taken, with the stream idle.
  task automatic send_frame(input frame_rec_t r);
    logic [7:0] d;
    logic last;
    logic user;
    if (r.ok) sb.push_back({r.val, r.bb[0]});
    for (int i = 0; i < r.len; i++) begin
      if (i < 4) d = r.val[(3-i)*8 +: 8];
      else if (i == 63) d = r.bb;
      else d = 8'(i * 7);
      last = (i == r.len - 1);
      user = last ? r.user_last : r.gaps;
      send_beat(d, last, user, r.gaps ? int'($urandom_range(0, 2)) : 0);
    end
    @(negedge aclk);
    bus.s_eth_rx_tvalid = 1'b0;
    bus.s_eth_rx_tlast  = 1'b0;
    bus.s_eth_rx_tuser  = 1'b0;
  endtask

  task automatic run_record(input frame_rec_t r);
    send_frame(r);
    if (r.err) exp_errs++;
    check("err_after_tlast", 64'(frame_error), 64'(r.err && r.len <= 64));
    check("busy_after_tlast", 64'(busy), 64'(r.ok));
    check("valid_after_tlast", 64'(bus.m_abp_valid), 64'(r.ok));
    if (r.ok) begin
      @(negedge aclk);
      check("valid_one_cycle", 64'(bus.m_abp_valid), 64'd0);
      check("err_on_good", 64'(frame_error), 64'd0);
    end
    repeat (2) @(negedge aclk);
  endtask

  initial begin
    frame_rec_t tbl[6];
    frame_rec_t f;
    frame_rec_t f2;

    tbl[0] = '{64, 32'h12345678, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{60, 32'hDEADBEEF, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{64, 32'hA5A5A5A5, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{70, 32'h11223344, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{64, 32'h55667788, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{64, 32'hCAFEF00D, 8'h03, 1'b0, 1'b1, 1'b1, 1'b0};

    bus.s_eth_rx_tvalid = 1'b0;
    bus.s_eth_rx_tdata  = 8'h00;
    bus.s_eth_rx_tlast  = 1'b0;
    bus.s_eth_rx_tuser  = 1'b0;
    bus.m_abp_ready     = 1'b1;

    repeat (3) @(negedge aclk);
    check("rst_tready", 64'(bus.s_eth_rx_tready), 64'd0);
    check("rst_valid", 64'(bus.m_abp_valid), 64'd0);
    check("rst_value", 64'(bus.m_abp_value), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    resetn = 1'b1;
    @(negedge aclk);
    check("tready_after_rst", 64'(bus.s_eth_rx_tready), 64'd1);

    for (int k = 0; k < 6; k++) run_record(tbl[k]);

    // Downstream stalls for 10 cycles while the next frame is already waiting.
    bus.m_abp_ready = 1'b0;
    f  = '{64, 32'h12345678, 8'hFE, 1'b0, 1'b0, 1'b1, 1'b0};
    f2 = '{64, 32'h87654321, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0};
    send_frame(f);
    fork
      send_frame(f2);
      begin
        for (int c = 0; c < 10; c++) begin
          check("hold_valid", 64'(bus.m_abp_valid), 64'd1);
          check("hold_value", 64'(bus.m_abp_value), 64'h12345678);
          check("hold_bit", 64'(bus.m_abp_bit), 64'd0);
          check("hold_tready", 64'(bus.s_eth_rx_tready), 64'd0);
          @(negedge aclk);
        end
        @(posedge aclk);
        #1 bus.m_abp_ready = 1'b1;
      end
    join
    check("second_valid", 64'(bus.m_abp_valid), 64'd1);
    check("second_value", 64'(bus.m_abp_value), 64'h87654321);
    repeat (3) @(negedge aclk);

    // Reset partway through a frame.
    for (int i = 0; i < 20; i++) send_beat(8'(i + 8'h40), 1'b0, 1'b0, 0);
    @(negedge aclk);
    bus.s_eth_rx_tvalid = 1'b0;
    check("busy_mid_frame", 64'(busy), 64'd1);
    resetn = 1'b0;
    @(negedge aclk);
    check("midrst_tready", 64'(bus.s_eth_rx_tready), 64'd0);
    check("midrst_valid", 64'(bus.m_abp_valid), 64'd0);
    check("midrst_value", 64'(bus.m_abp_value), 64'd0);
    check("midrst_bit", 64'(bus.m_abp_bit), 64'd0);
    check("midrst_err", 64'(frame_error), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    resetn = 1'b1;
    @(negedge aclk);
    check("midrst_tready_up", 64'(bus.s_eth_rx_tready), 64'd1);
    run_record('{64, 32'h00000001, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0});

    check("error_pulse_count", 64'(errs_seen), 64'(exp_errs));
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule

// File: doc/abp_packet_rx.md
Name: abp_packet_rx

Overview:
Alternating-bit-protocol packet receiver. It consumes Ethernet frame bytes from the MAC RX AXI-Stream and parses fixed-size ABP packets. Each packet carries a VALUE_SIZE-byte value, most significant byte first at byte 0, and the alternating bit in bit 0 of the final byte. It emits one ABP hyperdata transfer per valid frame, and that transfer feeds the ABP packet transmitter directly downstream. Malformed frames are dropped and flagged.

Parameters:
DATA_WIDTH, 8, width of RX AXI-Stream data in bits (fixed to 8, one byte per beat)
VALUE_SIZE, 4, number of value bytes at the start of the packet; must satisfy VALUE_SIZE < PACKET_SIZE
PACKET_SIZE, 64, exact number of bytes in a valid ABP frame

Ports:
aclk  input  1  clock; all logic on the rising edge
resetn  input  1  synchronous, active-low reset
s_eth_rx_tvalid  input  1  MAC RX beat valid
s_eth_rx_tdata  input  DATA_WIDTH  MAC RX byte
s_eth_rx_tlast  input  1  last byte of frame
s_eth_rx_tuser  input  1  MAC bad-frame flag, sampled only on the tlast beat
s_eth_rx_tready  output  1  receiver accepts a beat
m_abp_valid  output  1  parsed hyperdata valid
m_abp_ready  input  1  downstream accepts hyperdata
m_abp_value  output  VALUE_SIZE*8  parsed value, byte 0 = MSB
m_abp_bit  output  1  parsed alternating bit
frame_error  output  1  one-cycle pulse for each dropped frame
busy  output  1  high while a frame is partially received or a result is held

Behaviour:
- Reset (resetn=0 at a clock edge):
  - s_eth_rx_tready=0, m_abp_valid=0, m_abp_value=0, m_abp_bit=0, frame_error=0, busy=0.
  - State goes to RECV and the byte counter clears.
  - s_eth_rx_tready rises on the first cycle after reset is released.
- Reset mid-frame or mid-hold discards all partial state. The next beat after reset is treated as byte 0 of a new frame.
- All outputs are registered.
- A beat transfers when s_eth_rx_tvalid and s_eth_rx_tready are both high. Beats with tvalid=0 leave the state unchanged, so gaps are legal anywhere in a frame.
- Byte counter:
  - Width is $clog2(PACKET_SIZE)+1.
  - Counts accepted beats within the current frame.
  - Resets to 0 after any tlast beat.
- State RECV (tready=1):
  - Beat with index i < VALUE_SIZE: the byte is stored into the value shadow register at bits [(VALUE_SIZE-1-i)*8 +: 8].
  - Beats with VALUE_SIZE <= i < PACKET_SIZE-1: padding, ignored.
  - Beat with i = PACKET_SIZE-1 and tlast=1 and tuser=0: latch m_abp_bit=tdata[0] and m_abp_value=shadow; m_abp_valid=1 and tready=0 from the next cycle; go to HOLD. Latency is 1 cycle from the tlast beat to m_abp_valid.
  - Beat with tlast=1 and (i != PACKET_SIZE-1 or tuser=1): frame_error pulses next cycle, stay in RECV, no output.
  - Beat with i = PACKET_SIZE-1 and tlast=0 (long frame): frame_error pulses next cycle, go to DROP.
- State HOLD (tready=0, m_abp_valid=1):
  - m_abp_value and m_abp_bit stay stable until m_abp_valid and m_abp_ready are both high.
  - On that handshake: m_abp_valid=0 and tready=1 next cycle; go to RECV.
  - m_abp_ready high in the same cycle valid rises completes the transfer in one cycle.
- State DROP (tready=1):
  - Consumes beats and discards them.
  - On the tlast beat, go to RECV with the counter cleared. No second error pulse.
- frame_error: exactly one pulse per dropped frame, never asserted together with m_abp_valid rising.
- busy = (counter != 0) or HOLD or DROP.
- The value is passed through unmodified. Increment and bit handling belong downstream.

Decomposition:
- Shared package abp_pkg holds:
  - defaults ABP_PACKET_SIZE=64 and ABP_VALUE_SIZE=4
  - the constant ABP_BIT_OFFSET = PACKET_SIZE-1
  - typedef enum abp_rx_state_t {RECV, HOLD, DROP}
- The transmitter uses the same constants.
- Single module. No sub-module is warranted.

Test Plan:
1. 64-byte frame, bytes 0..3 = 12 34 56 78, byte 63 = 0x01, m_abp_ready=1 -> m_abp_valid=1 for exactly 1 cycle, starting 1 cycle after tlast, with value 0x12345678, bit=1, frame_error=0.
2. Same frame with bit byte 0xFE, m_abp_ready=0 for 10 cycles, second frame offered immediately -> valid held with value and bit (0) stable. tready=0 throughout; second frame accepted only after the handshake and parsed correctly.
3. 60-byte frame with tlast on byte 59 -> one frame_error pulse, no m_abp_valid. The following good frame (value 0xA5A5A5A5, bit 0) is output correctly.
4. 70-byte frame -> frame_error pulse after byte 63. Bytes 64..69 are consumed with tready=1, no output, busy falls after tlast.
5. Good-length frame with tuser=1 on tlast -> frame_error pulse, no output. Random tvalid gaps on a good frame -> correct output.
6. resetn low for 1 cycle after 20 bytes -> all outputs 0. Next 64-byte frame with value 0x00000001, bit 1 parses correctly from byte 0.
